instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/fetch_buffer.sv | 77 +++++++
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch unit.
//   fetch_state_t : fetch controller states (IDLE, REQ, DISCARD)
//   fetch_entry_t : one buffered instruction with its address
//   FETCH_BUF_DEPTH / FETCH_CNT_W / FETCH_BUF_FULL : buffer sizing
//   align_word()  : clears the byte-offset bits of a fetch address
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int FETCH_BUF_DEPTH = 2;
  localparam int FETCH_CNT_W     = $clog2(FETCH_BUF_DEPTH + 1);
  localparam logic [FETCH_CNT_W-1:0] FETCH_BUF_FULL = FETCH_CNT_W'(FETCH_BUF_DEPTH);

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: bundles the fetch unit's external handshakes.
//   Memory side : ImemReq/ImemAddr out, ImemAck/ImemData in
//   Decode side : InstrValid/Instr/InstrPC out, InstrReady in
//   Redirect    : Redirect/RedirectPC in (branch/jump from a later stage)
// master = the fetch unit, slave = memory + decode + redirect source.
interface instruction_fetch_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        Redirect;
  logic [31:0] RedirectPC;

  modport master (
    output ImemReq, ImemAddr, InstrValid, Instr, InstrPC,
    input  ImemAck, ImemData, InstrReady, Redirect, RedirectPC
  );

  modport slave (
    input  ImemReq, ImemAddr, InstrValid, Instr, InstrPC,
    output ImemAck, ImemData, InstrReady, Redirect, RedirectPC
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetch_entry_t between memory and decode.
//   clk, rst   : clock, synchronous active-high reset (count only)
//   push       : write entry_in at the tail
//   entry_in   : entry to write
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; dominates push and pop
//   count      : current occupancy
//   count_next : occupancy after this cycle's push/pop/flush
//   head       : oldest entry, all zeros when empty
// Entries are kept in a shift arrangement: slot0 is always the head, so the
// read side needs no pointer and pop just moves slot1 down.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           entry_in,
  input  logic                   pop,
  input  logic                   flush,
  output logic [FETCH_CNT_W-1:0] count,
  output logic [FETCH_CNT_W-1:0] count_next,
  output fetch_entry_t           head
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic         pop_eff;
  logic         push_eff;
  logic         wr_slot0;

  assign pop_eff  = pop && (count != '0);
  assign push_eff = push && ((count != FETCH_BUF_FULL) || pop_eff);
  // New entry lands in slot0 if the FIFO is (or is becoming) empty.
  assign wr_slot0 = (count == '0) || ((count == FETCH_CNT_W'(1)) && pop_eff);

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10:   count_next = count + FETCH_CNT_W'(1);
        2'b01:   count_next = count - FETCH_CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Payload is not reset: it is only visible through head, which is gated
  // by count.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (pop_eff) begin
        slot0 <= slot1;
      end
      if (push_eff) begin
        if (wr_slot0) begin
          slot0 <= entry_in;
        end else begin
          slot1 <= entry_in;
        end
      end
    end
  end

  assign head = (count != '0) ? slot0 : '0;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential instruction fetch with redirect support.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : instruction_fetch_if.master
//          ImemReq/ImemAddr/ImemAck/ImemData - single-outstanding memory port
//          InstrValid/InstrReady/Instr/InstrPC - decode handshake
//          Redirect/RedirectPC - flush and reload the fetch PC
// Parameter RESET_PC is the first fetch address after reset.
// The controller keeps at most one memory request in flight. ImemAddr comes
// from its own register so that a request overtaken by a redirect keeps its
// original address until the memory completes it (DISCARD state), while the
// PC already points at the redirect target.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  fetch_state_t             state;
  fetch_state_t             state_nxt;
  logic [31:0]              pc;
  logic [31:0]              pc_nxt;
  logic [31:0]              addr_q;
  logic [31:0]              addr_nxt;

  logic                     buf_push;
  logic                     buf_pop;
  fetch_entry_t             buf_in;
  fetch_entry_t             buf_head;
  logic [FETCH_CNT_W-1:0]   buf_count;
  logic [FETCH_CNT_W-1:0]   buf_count_next;

  // Only a live (non-discarded) completion without a same-cycle redirect
  // is written into the buffer.
  assign buf_push = (state == REQ) && bus.ImemAck && !bus.Redirect;
  assign buf_pop  = (buf_count != '0) && bus.InstrReady;
  assign buf_in   = '{pc: addr_q, instr: bus.ImemData};

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (buf_push),
    .entry_in   (buf_in),
    .pop        (buf_pop),
    .flush      (bus.Redirect),
    .count      (buf_count),
    .count_next (buf_count_next),
    .head       (buf_head)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = addr_q;

    if (bus.Redirect) begin
      pc_nxt = align_word(bus.RedirectPC);
    end

    // ImemAck is only looked at while a request is outstanding.
    unique case (state)
      IDLE: begin
        if (buf_count != FETCH_BUF_FULL) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.ImemAck) begin
          if (bus.Redirect) begin
            state_nxt = REQ;
          end else begin
            pc_nxt    = pc + 32'd4;
            state_nxt = (buf_count_next != FETCH_BUF_FULL) ? REQ : IDLE;
          end
        end else if (bus.Redirect) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.ImemAck) begin
          state_nxt = REQ;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A request held in REQ already has addr_q == pc, so reloading the
    // address whenever the next state is REQ is safe for every path.
    if (state_nxt == REQ) begin
      addr_nxt = pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      addr_q <= addr_nxt;
    end
  end

  assign bus.ImemReq    = (state != IDLE);
  assign bus.ImemAddr   = addr_q;
  assign bus.InstrValid = (buf_count != '0);
  assign bus.Instr      = buf_head.instr;
  assign bus.InstrPC    = buf_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC_A = 32'h0000_0000;
  localparam logic [31:0] RST_PC_B = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if fa();
  instruction_fetch_if fb();

  instruction_fetch #(.RESET_PC(RST_PC_A)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (fa.master)
  );

  instruction_fetch #(.RESET_PC(RST_PC_B)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (fb.master)
  );

  int errors = 0;
  int checks = 0;
  int mode   = 0;      // 0: ack driven by hand, 1: zero-wait, 2: random latency
  bit chk_en = 1'b0;

  // Reference model: one outstanding request, a queue of fetched words.
  logic         m_pend  = 1'b0;
  logic         m_stale = 1'b0;
  logic [31:0]  m_addr  = '0;
  logic [31:0]  m_pc    = '0;
  fetch_entry_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int           sz0;
    logic         ack;
    logic         take;
    logic         pop;
    fetch_entry_t e;
    sz0 = mq.size();
    if (rst) begin
      m_pend  = 1'b0;
      m_stale = 1'b0;
      m_pc    = RST_PC_A;
      mq.delete();
      return;
    end
    ack  = m_pend && (fa.ImemAck === 1'b1);
    take = ack && !m_stale && !fa.Redirect;
    pop  = (sz0 != 0) && (fa.InstrReady === 1'b1);
    if (fa.Redirect) begin
      mq.delete();
    end else begin
      if (pop) mq.delete(0);
      if (take) begin
        e.pc    = m_addr;
        e.instr = fa.ImemData;
        mq.push_back(e);
      end
    end
    if (fa.Redirect) m_pc = {fa.RedirectPC[31:2], 2'b00};
    else if (take)   m_pc = m_addr + 32'd4;
    if (m_pend) begin
      if (ack) begin
        if (fa.Redirect || m_stale || mq.size() < 2) begin
          m_stale = 1'b0;
          m_addr  = m_pc;
        end else begin
          m_pend = 1'b0;
        end
      end else if (fa.Redirect) begin
        m_stale = 1'b1;
      end
    end else if (sz0 < 2) begin
      m_pend  = 1'b1;
      m_stale = 1'b0;
      m_addr  = m_pc;
    end
  endtask

  always @(posedge clk) model_step();

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ImemReq", 32'(fa.ImemReq), 32'(m_pend));
      if (m_pend) chk("ImemAddr", fa.ImemAddr, m_addr);
      chk("InstrValid", 32'(fa.InstrValid), 32'(mq.size() != 0));
      chk("Instr", fa.Instr, (mq.size() != 0) ? mq[0].instr : 32'h0);
      chk("InstrPC", fa.InstrPC, (mq.size() != 0) ? mq[0].pc : 32'h0);
    end
  end

  task automatic step();
    @(negedge clk);
    fa.ImemData = $urandom;
    case (mode)
      1:       fa.ImemAck = fa.ImemReq;
      2:       fa.ImemAck = ($urandom_range(0, 2) != 0);
      default: fa.ImemAck = 1'b0;
    endcase
    fb.ImemAck  = fb.ImemReq;
    fb.ImemData = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fa.Redirect = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0;
    logic [31:0] rpc;
    fa.ImemAck = 1'b0; fa.ImemData = '0; fa.InstrReady = 1'b1;
    fa.Redirect = 1'b0; fa.RedirectPC = '0;
    fb.ImemAck = 1'b0; fb.ImemData = '0; fb.InstrReady = 1'b1;
    fb.Redirect = 1'b0; fb.RedirectPC = '0;

    // Reset release, zero-wait memory, decode always ready.
    mode = 1;
    do_reset();
    chk_en = 1'b1;
    chk("rst_ImemReq", 32'(fa.ImemReq), 32'h0);
    chk("rst_InstrValid", 32'(fa.InstrValid), 32'h0);
    chk("rst_Instr", fa.Instr, 32'h0);
    chk("rst_InstrPC", fa.InstrPC, 32'h0);
    chk("rst_wrap_ImemReq", 32'(fb.ImemReq), 32'h0);
    step();
    d0 = fa.ImemData;
    chk("t1_addr0", fa.ImemAddr, 32'h0);
    chk("wrap_addr0", fb.ImemAddr, 32'hFFFF_FFF8);
    step();
    chk("t1_addr1", fa.ImemAddr, 32'h4);
    chk("t1_valid", 32'(fa.InstrValid), 32'h1);
    chk("t1_pc0", fa.InstrPC, 32'h0);
    chk("t1_instr0", fa.Instr, d0);
    chk("model_addr1", m_addr, 32'h4);
    chk("wrap_addr1", fb.ImemAddr, 32'hFFFF_FFFC);
    step();
    chk("t1_addr2", fa.ImemAddr, 32'h8);
    chk("t1_pc1", fa.InstrPC, 32'h4);
    chk("wrap_addr2", fb.ImemAddr, 32'h0000_0000);
    chk("wrap_pc1", fb.InstrPC, 32'hFFFF_FFFC);

    // Decode stalled for five cycles: buffer fills, fetch stops.
    fa.InstrReady = 1'b0;
    do_reset();
    step(); step(); step();
    chk("t2_req_low", 32'(fa.ImemReq), 32'h0);
    step(); step();
    chk("t2_req_low2", 32'(fa.ImemReq), 32'h0);
    chk("t2_head", fa.InstrPC, 32'h0);
    chk("model_depth", 32'(mq.size()), 32'h2);
    fa.InstrReady = 1'b1;
    step();
    chk("t2_second", fa.InstrPC, 32'h4);
    chk("t2_req_still_low", 32'(fa.ImemReq), 32'h0);
    step();
    chk("t2_req_again", 32'(fa.ImemReq), 32'h1);
    chk("t2_addr8", fa.ImemAddr, 32'h8);

    // Slow memory, redirect while the request is in flight.
    mode = 0;
    do_reset();
    step();
    chk("t3_addr0", fa.ImemAddr, 32'h0);
    step();
    fa.Redirect = 1'b1; fa.RedirectPC = 32'h100;
    step();
    fa.Redirect = 1'b0;
    chk("t3_addr_held", fa.ImemAddr, 32'h0);
    chk("t3_novalid", 32'(fa.InstrValid), 32'h0);
    step();
    fa.ImemAck = 1'b1;
    chk("t3_addr_held2", fa.ImemAddr, 32'h0);
    step();
    chk("t3_newaddr", fa.ImemAddr, 32'h100);
    chk("t3_novalid2", 32'(fa.InstrValid), 32'h0);
    fa.ImemAck = 1'b1;
    step();
    chk("t3_pc100", fa.InstrPC, 32'h100);
    chk("t3_addr104", fa.ImemAddr, 32'h104);

    // Redirect coincident with the ack, unaligned target.
    mode = 1;
    do_reset();
    step();
    fa.Redirect = 1'b1; fa.RedirectPC = 32'h203;
    step();
    fa.Redirect = 1'b0;
    chk("t4_novalid", 32'(fa.InstrValid), 32'h0);
    chk("t4_addr200", fa.ImemAddr, 32'h200);
    step();
    chk("t4_pc200", fa.InstrPC, 32'h200);

    // Reset while a request is pending, ack arrives afterwards.
    mode = 0;
    do_reset();
    step();
    chk("t5_pending", 32'(fa.ImemReq), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    fa.ImemAck = 1'b1;
    chk("t5_req_low", 32'(fa.ImemReq), 32'h0);
    step();
    chk("t5_novalid", 32'(fa.InstrValid), 32'h0);
    chk("t5_restart", fa.ImemAddr, RST_PC_A);
    step();
    chk("t5_novalid2", 32'(fa.InstrValid), 32'h0);

    // Randomized traffic against the model.
    mode = 2;
    for (int i = 0; i < 3000; i++) begin
      step();
      fa.InstrReady = ($urandom_range(0, 3) != 0);
      fa.Redirect   = ($urandom_range(0, 11) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc[31:4] = 28'hFFF_FFFF;
      fa.RedirectPC = rpc;
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    fa.Redirect = 1'b0;
    step();
    step();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
